vc_to_dest_arbiter: RTL and testbench

- Downstream stage of the VC0/VC1 virtual-channel FIFOs.
- Pops words from the two VC FIFOs with strict priority: VC0 first, VC1 second.
- Routes each popped word to destination FIFO D0 or D1 according to a destination bit inside the word.
- Applies per-destination backpressure with hysteresis, because the FIFO almost-full/almost-empty flags are equality pulses and not levels.

---
 rtl/vc_to_dest_arbiter_pkg.sv | 14 +
 rtl/vc_to_dest_arbiter_dest_hold_ctrl.sv | 35 +++
 rtl/vc_to_dest_arbiter.sv | 157 +++++++++++++++
 tb/tb_vc_to_dest_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_to_dest_arbiter_pkg.sv
// Shared types and constants for the VC-to-destination arbiter.
package vc_to_dest_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/vc_to_dest_arbiter_dest_hold_ctrl.sv
// Per-destination backpressure flag: turns the almost-full/almost-empty
// equality pulses into a level with hysteresis.
module dest_hold_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic full,
  input  logic almost_full,
  input  logic almost_empty,
  input  logic empty,
  output logic hold
);

  logic hold_q, hold_d;

  // Setting dominates so a simultaneous fill/drain pulse never releases the hold.
  always_comb begin
    hold_d = hold_q;
    if (full || almost_full) begin
      hold_d = 1'b1;
    end else if (almost_empty || empty) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;

endmodule

// File: rtl/vc_to_dest_arbiter.sv
// Strict-priority pop from VC0/VC1 and routing of each word to D0 or D1
// through a two-stage registered pipeline.
module vc_to_dest_arbiter
  import vc_to_dest_arbiter_pkg::*;
#(
  parameter int data_width = 6,
  parameter int dest_bit   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  error_VC0,
  input  logic                  error_VC1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  almost_empty_D0,
  input  logic                  almost_empty_D1,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_D0,
  output logic [data_width-1:0] data_D1,
  output logic                  active_out,
  output logic                  idle_out,
  output logic                  error_out
);

  logic rst_n;
  assign rst_n = reset & init;

  logic [1:0] full_v, afull_v, aempty_v, empty_v, hold_v;
  assign full_v   = {full_D1, full_D0};
  assign afull_v  = {almost_full_D1, almost_full_D0};
  assign aempty_v = {almost_empty_D1, almost_empty_D0};
  assign empty_v  = {empty_D1, empty_D0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    dest_hold_ctrl u_hold (
      .clk          (clk),
      .rst_n        (rst_n),
      .full         (full_v[gi]),
      .almost_full  (afull_v[gi]),
      .almost_empty (aempty_v[gi]),
      .empty        (empty_v[gi]),
      .hold         (hold_v[gi])
    );
  end

  state_e state_q, state_d;
  logic pop0_q, pop0_d, pop1_q, pop1_d;
  logic s1_valid_q, s1_valid_d, s1_src_q, s1_src_d;
  logic push0_q, push0_d, push1_q, push1_d;
  logic [data_width-1:0] data0_q, data0_d, data1_q, data1_d;
  logic active_q, active_d, idle_q, idle_d, error_q, error_d;

  logic can_pop, run, drained;
  logic [data_width-1:0] word;

  always_comb begin
    can_pop = !hold_v[0] && !hold_v[1] && !full_D0 && !full_D1;
    run     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    drained = !pop0_q && !pop1_q && !s1_valid_q;
    // s1_src_q selects which FIFO's read data belongs to the word in flight.
    word    = s1_src_q ? data_out_VC1 : data_out_VC0;

    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_IDLE;
      ST_IDLE:   if (can_pop && (!empty_fifo_VC0 || !empty_fifo_VC1)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (empty_fifo_VC0 && empty_fifo_VC1 && drained) state_d = ST_IDLE;
      default:   state_d = ST_ERROR;
    endcase
    if (error_VC0 || error_VC1) begin
      state_d = ST_ERROR;
    end

    pop0_d     = 1'b0;
    pop1_d     = 1'b0;
    s1_valid_d = 1'b0;
    s1_src_d   = 1'b0;
    push0_d    = 1'b0;
    push1_d    = 1'b0;
    data0_d    = '0;
    data1_d    = '0;

    // Entering or sitting in ERROR drops everything in flight.
    if (state_d != ST_ERROR) begin
      pop0_d     = run && can_pop && !empty_fifo_VC0;
      pop1_d     = run && can_pop && empty_fifo_VC0 && !empty_fifo_VC1;
      s1_valid_d = pop0_q || pop1_q;
      s1_src_d   = pop1_q;
      if (s1_valid_q) begin
        if (word[dest_bit] == DEST_D1) begin
          push1_d = 1'b1;
          data1_d = word;
        end else if (word[dest_bit] == DEST_D0) begin
          push0_d = 1'b1;
          data0_d = word;
        end
      end
    end

    active_d = (state_d == ST_ACTIVE);
    idle_d   = (state_d == ST_IDLE);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      pop0_q     <= 1'b0;
      pop1_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= 1'b0;
      push0_q    <= 1'b0;
      push1_q    <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      active_q   <= 1'b0;
      idle_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop0_q     <= pop0_d;
      pop1_q     <= pop1_d;
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      push0_q    <= push0_d;
      push1_q    <= push1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      active_q   <= active_d;
      idle_q     <= idle_d;
      error_q    <= error_d;
    end
  end

  assign pop_VC0    = pop0_q;
  assign pop_VC1    = pop1_q;
  assign push_D0    = push0_q;
  assign push_D1    = push1_q;
  assign data_D0    = data0_q;
  assign data_D1    = data1_q;
  assign active_out = active_q;
  assign idle_out   = idle_q;
  assign error_out  = error_q;

endmodule

// File: tb/tb_vc_to_dest_arbiter.sv
// Directed bench for vc_to_dest_arbiter; two small FIFO models feed the VC side.
module tb_vc_to_dest_arbiter;

  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, init;
  logic empty_fifo_VC0 = 1'b1, empty_fifo_VC1 = 1'b1;
  logic [W-1:0] data_out_VC0 = '0, data_out_VC1 = '0;
  logic error_VC0, error_VC1;
  logic full_D0, full_D1, almost_full_D0, almost_full_D1;
  logic almost_empty_D0, almost_empty_D1, empty_D0, empty_D1;
  logic pop_VC0, pop_VC1, push_D0, push_D1;
  logic [W-1:0] data_D0, data_D1;
  logic active_out, idle_out, error_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  vc_to_dest_arbiter #(.data_width(W), .dest_bit(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .error_VC0(error_VC0), .error_VC1(error_VC1),
    .full_D0(full_D0), .full_D1(full_D1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .almost_empty_D0(almost_empty_D0), .almost_empty_D1(almost_empty_D1),
    .empty_D0(empty_D0), .empty_D1(empty_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_D0(data_D0), .data_D1(data_D1),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

  // Registered-read FIFO models; empty already accounts for a pending pop.
  always @(posedge clk) begin
    if (pop_VC0 && q0.size() > 0) data_out_VC0 <= q0.pop_front();
    if (pop_VC1 && q1.size() > 0) data_out_VC1 <= q1.pop_front();
  end

  always @(negedge clk) begin
    empty_fifo_VC0 = (q0.size() == 0) || (q0.size() == 1 && pop_VC0);
    empty_fifo_VC1 = (q1.size() == 0) || (q1.size() == 1 && pop_VC1);
    if (push_D0) $display("%0t push D0 data=%h", $time, data_D0);
    if (push_D1) $display("%0t push D1 data=%h", $time, data_D1);
  end

  wire [18:0] all_outs = {pop_VC0, pop_VC1, push_D0, push_D1, data_D0, data_D1,
                          active_out, idle_out, error_out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!idle_out && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (idle_out !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: idle_out=%b after %0d cycles, want 1", idle_out, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (all_outs !== 19'd0) begin
        errors++;
        $display("FAIL reset_outs: got %h want 0", all_outs);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({active_out, idle_out, error_out} !== 3'b010) begin
      errors++;
      $display("FAIL reset_release: state bits %b want 010", {active_out, idle_out, error_out});
    end
    $display("reset entry/release done");
  endtask

  task automatic test_priority();
    q0.push_back(6'h12);
    q1.push_back(6'h05);
    tick();
    checks++;
    if ({pop_VC0, pop_VC1, active_out} !== 3'b101) begin
      errors++;
      $display("FAIL prio_first_pop: pop0,pop1,active=%b want 101", {pop_VC0, pop_VC1, active_out});
    end
    tick();
    checks++;
    if ({pop_VC0, pop_VC1} !== 2'b01) begin
      errors++;
      $display("FAIL prio_second_pop: pop0,pop1=%b want 01", {pop_VC0, pop_VC1});
    end
    tick();
    checks++;
    if ({push_D0, push_D1, pop_VC0, pop_VC1} !== 4'b0100 || data_D1 !== 6'h12 || data_D0 !== 6'h00) begin
      errors++;
      $display("FAIL prio_push_d1: push0,push1,pop0,pop1=%b d0=%h d1=%h want 0100 00 12",
               {push_D0, push_D1, pop_VC0, pop_VC1}, data_D0, data_D1);
    end
    tick();
    checks++;
    if ({push_D0, push_D1} !== 2'b10 || data_D0 !== 6'h05 || data_D1 !== 6'h00) begin
      errors++;
      $display("FAIL prio_push_d0: push0,push1=%b d0=%h d1=%h want 10 05 00",
               {push_D0, push_D1}, data_D0, data_D1);
    end
    tick();
    checks++;
    if ({push_D0, push_D1, idle_out} !== 3'b001) begin
      errors++;
      $display("FAIL prio_drain: push0,push1,idle=%b want 001", {push_D0, push_D1, idle_out});
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] words [4] = '{6'h01, 6'h12, 6'h03, 6'h14};
    logic         to_d1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) q1.push_back(words[i]);
    for (int i = 0; i < 6; i++) begin
      logic exp_pop;
      exp_pop = (i < 4);
      tick();
      checks++;
      if (pop_VC1 !== exp_pop || pop_VC0 !== 1'b0) begin
        errors++;
        $display("FAIL stream_pop[%0d]: pop0=%b pop1=%b want 0 %b", i, pop_VC0, pop_VC1, exp_pop);
      end
      if (i >= 2) begin
        logic [W-1:0] exp_d0, exp_d1;
        exp_d0 = to_d1[i-2] ? 6'h00 : words[i-2];
        exp_d1 = to_d1[i-2] ? words[i-2] : 6'h00;
        checks++;
        if (push_D0 !== !to_d1[i-2] || push_D1 !== to_d1[i-2] || data_D0 !== exp_d0 || data_D1 !== exp_d1) begin
          errors++;
          $display("FAIL stream_push[%0d]: push0=%b push1=%b d0=%h d1=%h want %b %b %h %h",
                   i - 2, push_D0, push_D1, data_D0, data_D1, !to_d1[i-2], to_d1[i-2], exp_d0, exp_d1);
        end
      end
    end
    tick();
    checks++;
    if ({push_D0, push_D1, idle_out} !== 3'b001) begin
      errors++;
      $display("FAIL stream_drain: push0,push1,idle=%b want 001", {push_D0, push_D1, idle_out});
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) q0.push_back(W'(i));
    tick();
    checks++;
    if (pop_VC0 !== 1'b1) begin errors++; $display("FAIL bp_pop1: pop0=%b want 1", pop_VC0); end
    almost_full_D0 = 1'b1;
    tick();
    checks++;
    if (pop_VC0 !== 1'b1) begin errors++; $display("FAIL bp_pop_same_cycle: pop0=%b want 1", pop_VC0); end
    almost_full_D0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pop_VC0 !== 1'b0 || push_D0 !== 1'b1 || data_D0 !== W'(i)) begin
        errors++;
        $display("FAIL bp_inflight[%0d]: pop0=%b push0=%b d0=%h want 0 1 %h", i, pop_VC0, push_D0, data_D0, W'(i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1} !== 4'b0000) begin
        errors++;
        $display("FAIL bp_held[%0d]: pops/pushes=%b want 0000", i, {pop_VC0, pop_VC1, push_D0, push_D1});
      end
    end
    almost_empty_D0 = 1'b1;
    tick();
    checks++;
    if (pop_VC0 !== 1'b0) begin errors++; $display("FAIL bp_release_edge: pop0=%b want 0", pop_VC0); end
    almost_empty_D0 = 1'b0;
    tick();
    checks++;
    if (pop_VC0 !== 1'b1) begin errors++; $display("FAIL bp_resume: pop0=%b want 1", pop_VC0); end
    tick();
    tick();
    checks++;
    if (push_D0 !== 1'b1 || data_D0 !== 6'h02) begin
      errors++;
      $display("FAIL bp_resume_push: push0=%b d0=%h want 1 02", push_D0, data_D0);
    end
    wait_idle(20);
  endtask

  task automatic test_full_push();
    q0.push_back(6'h07);
    tick();
    full_D0 = 1'b1;
    tick();
    tick();
    checks++;
    if (push_D0 !== 1'b1 || data_D0 !== 6'h07) begin
      errors++;
      $display("FAIL full_push: push0=%b d0=%h want 1 07", push_D0, data_D0);
    end
    full_D0  = 1'b0;
    empty_D0 = 1'b1;
    tick();
    empty_D0 = 1'b0;
    wait_idle(10);
  endtask

  task automatic test_error();
    q0.push_back(6'h10);
    q0.push_back(6'h11);
    q0.push_back(6'h12);
    q0.push_back(6'h13);
    tick();
    tick();
    checks++;
    if (pop_VC0 !== 1'b1) begin errors++; $display("FAIL err_prepop: pop0=%b want 1", pop_VC0); end
    error_VC1 = 1'b1;
    tick();
    checks++;
    if ({pop_VC0, pop_VC1, push_D0, push_D1, active_out, idle_out, error_out} !== 7'b0000001) begin
      errors++;
      $display("FAIL err_enter: pops/pushes/state=%b want 0000001",
               {pop_VC0, pop_VC1, push_D0, push_D1, active_out, idle_out, error_out});
    end
    error_VC1 = 1'b0;
    q0.delete();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({pop_VC0, pop_VC1, push_D0, push_D1, error_out} !== 5'b00001) begin
        errors++;
        $display("FAIL err_sticky[%0d]: pops/pushes/err=%b want 00001", i, {pop_VC0, pop_VC1, push_D0, push_D1, error_out});
      end
    end
    init = 1'b0;
    tick();
    checks++;
    if (all_outs !== 19'd0) begin errors++; $display("FAIL err_init: outs=%h want 0", all_outs); end
    init = 1'b1;
    tick();
    checks++;
    if ({active_out, idle_out, error_out} !== 3'b010) begin
      errors++;
      $display("FAIL err_reinit_idle: state bits %b want 010", {active_out, idle_out, error_out});
    end
  endtask

  task automatic test_reset_midflight();
    q1.push_back(6'h15);
    tick();
    checks++;
    if (pop_VC1 !== 1'b1) begin errors++; $display("FAIL mid_pop: pop1=%b want 1", pop_VC1); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (all_outs !== 19'd0) begin errors++; $display("FAIL mid_reset[%0d]: outs=%h want 0", i, all_outs); end
    end
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({pop_VC0, pop_VC1, push_D0, push_D1, idle_out} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_after: pops/pushes/idle=%b want 00001", {pop_VC0, pop_VC1, push_D0, push_D1, idle_out});
    end
  endtask

  initial begin
    reset = 1'b0; init = 1'b1;
    error_VC0 = 1'b0; error_VC1 = 1'b0;
    full_D0 = 1'b0; full_D1 = 1'b0;
    almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
    almost_empty_D0 = 1'b0; almost_empty_D1 = 1'b0;
    empty_D0 = 1'b0; empty_D1 = 1'b0;
    test_reset();
    test_priority();
    test_streaming();
    test_backpressure();
    test_full_push();
    test_error();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
